cbus_rr_arbiter: RTL

Parametrised N-input CBus arbiter with selectable fixed-priority or round-robin grant policy. It holds each grant for a whole burst and routes responses back only to the granted requester. Optionally, it applies MIPS kseg0/kseg1 virtual-to-physical translation on the outgoing address. It sits at the top level between the instruction/data cache and uncached bus adapters and the external `oreq`/`oresp` port, replacing the plain CBus arbiter plus separate translation stage.

---
 rtl/cbus_rr_arbiter_pkg.sv | 37 +++
 rtl/cbus_rr_arbiter_rr_picker.sv | 30 +++
 rtl/cbus_rr_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus request/response types plus arbiter policy encodings and KSEG translation helpers.
// The optional address translation is enabled by defining CBUS_ADDR_TRANS_EN.
package cbus_rr_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // len holds the number of beats minus one
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    // kseg0/kseg1 occupy 0x8000_0000..0xBFFF_FFFF and map onto the low 512 MiB
    function automatic logic [31:0] kseg_to_phys(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_picker.sv
// Combinational rotating-priority encoder: first valid index scanning base, base+1, ... modulo N.
module cbus_rr_arbiter_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_base,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W:0] w_cand;

    // Scan from the farthest offset down so the nearest valid index to base wins last.
    always_comb begin
        o_idx  = '0;
        o_any  = |i_valid;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_base} + (W + 1)'(k);
            if (w_cand >= (W + 1)'(N)) begin
                w_cand = w_cand - (W + 1)'(N);
            end
            if (i_valid[w_cand]) begin
                o_idx = w_cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-input CBus arbiter, fixed-priority or round-robin, holding each grant for a whole burst.
// Define CBUS_ADDR_TRANS_EN to translate kseg0/kseg1 addresses on oreq.addr.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int RR_POLICY  = ARB_RR,
    localparam int IDX_W     = $clog2(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic       [IDX_W-1:0]       grant_idx,
    output logic                         busy,
    output arb_state_e                   o_dbg_state
);

    // Handshake: a requester raises valid and holds valid plus all fields until the
    // beat where oresp.ready && oresp.last; each cycle with oresp.ready while BUSY
    // completes one beat, and ownership ends only on the ready && last beat.

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       r_rr_base;

    logic [NUM_INPUTS-1:0]  w_valid;
    logic [IDX_W-1:0]       w_pick_base;
    logic [IDX_W-1:0]       w_win;
    logic                   w_any;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_valid
        assign w_valid[g] = ireqs[g].valid;
    end

    assign w_pick_base = (RR_POLICY == ARB_RR) ? r_rr_base : '0;

    cbus_rr_arbiter_rr_picker #(
        .N (NUM_INPUTS),
        .W (IDX_W)
    ) u_rr_picker (
        .i_valid (w_valid),
        .i_base  (w_pick_base),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    // Arbitration only happens in IDLE, so a release cycle never re-grants.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_base   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_win;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        r_state <= ST_IDLE;
                        if (RR_POLICY == ARB_RR) begin
                            r_rr_base <= (r_grant_idx == IDX_W'(NUM_INPUTS - 1)) ?
                                         '0 : r_grant_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (r_state == ST_BUSY) begin
            oreq = ireqs[r_grant_idx];
`ifdef CBUS_ADDR_TRANS_EN
            oreq.addr = kseg_to_phys(ireqs[r_grant_idx].addr);
`endif
            iresps[r_grant_idx] = oresp;
        end
    end

    assign grant_idx   = r_grant_idx;
    assign busy        = (r_state == ST_BUSY);
    assign o_dbg_state = r_state;

endmodule
